ram_stream_ctrl: RTL and testbench
==================================

# ram_stream_ctrl

Sequencer and port arbiter for the single-port 32-bit on-chip RAM (`ram_v1`, 1024 words). It shares the RAM's single address/data/wren port between a word-write requester (host loader) and an internal burst reader. The burst reader streams a contiguous address range out as one Avalon-ST packet with full backpressure support. It sits between the RAM and the Avalon-ST sink that feeds the order-book datapath.

## Interface
Parameters:
- `WIDTH`, 32: RAM word and stream data width.
- `ADDR_W`, 10: RAM word-address width.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_req`  in  1  write request; held with `wr_addr`/`wr_data` until `wr_ack`.
- `wr_addr`  in  ADDR_W  write word address.
- `wr_data`  in  WIDTH  write data.
- `wr_ack`  out  1  combinational grant; the write occurs in this cycle.
- `start`  in  1  burst start strobe; honoured only while `busy`=0.
- `start_addr`  in  ADDR_W  first word address of the burst.
- `len`  in  ADDR_W+1  burst length in words, 0..1024.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at the end of a burst.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_data`  out  WIDTH  to RAM `data`.
- `ram_wren`  out  1  to RAM `wren`.
- `ram_q`  in  WIDTH  from RAM `q`; valid one cycle after the address is sampled.
- `ready`  in  1  Avalon-ST sink ready.
- `data`  out  WIDTH  stream data.
- `valid`  out  1  stream valid.
- `sop`  out  1  first beat of the packet.
- `eop`  out  1  last beat of the packet.
- `empty`  out  1  always 0 (only full words are sent).

## Operation
- The FSM has three states: IDLE, STREAM and DRAIN.
- IDLE + `start`: the block latches `start_addr` into the read pointer and `len` into the remaining count. `busy` goes to 1.
  - `len`=0 produces no packet. `done` pulses in the next cycle and the FSM returns to IDLE.
  - Otherwise the FSM moves to STREAM.
- STREAM: one read issue per cycle when the slot rule allows it (see below). Each issue increments the read pointer by 1 modulo 2^ADDR_W and decrements the remaining count. When the remaining count reaches 0 the FSM moves to DRAIN.
- DRAIN: the FSM waits until no read is in flight and the FIFO is empty. On the edge that transfers the `eop` beat, it returns to IDLE, drops `busy` and raises `done` for one cycle.
- Output buffering: a 2-entry FIFO captures `ram_q` on the edge after each issue. `data`, `sop` and `eop` are taken from the FIFO head.
- `sop` marks word 0 of the burst; `eop` marks word `len`-1. Both are 1 on a single-word burst.
- Slot rule: a read may issue only if FIFO count + reads in flight − pop this cycle < 2.
- Arbitration applies when a write and a read issue compete in the same cycle. A granted write drives `ram_wren`=1, `ram_address`=`wr_addr` and `ram_data`=`wr_data`, with `wr_ack`=1. A granted read drives `ram_wren`=0 and `ram_address`=read pointer.
- A write with no competing read is granted immediately, in any state.
- Ordering is by RAM port cycle: a write granted before the read of the same address is visible in the stream.
- `start` while `busy`=1 is ignored.
- Reset, asynchronous and including mid-burst: the FSM goes to IDLE and the FIFO is flushed. All outputs go to 0 (`valid`, `sop`, `eop`, `busy`, `done`, `wr_ack`, `ram_wren`, `ram_address`, `ram_data`, `data`). The partial packet is discarded, with no `eop`.

## Timing
- `start` is sampled at edge E0. Word 0's address is driven in the cycle after E0 and sampled by the RAM at E1. `ram_q` is captured at E2. `valid`=1 from E2.
- With `ready`=1 and no writes, the block sustains one beat per cycle. A burst of N words ends with `done` 2+N cycles after E0.
- Avalon-ST: a beat transfers on an edge with `valid`&`ready`=1. `valid` never drops, and `data`/`sop`/`eop` never change, while `valid`=1 and `ready`=0.
- `wr_ack` is combinational from `wr_req`, the FSM state and the arbitration state. There is no combinational path from `ready` to `valid`.

## Configuration
- `RAM_STREAM_CTRL_RR_ARB_EN` defined: round-robin arbitration. After a write grant, the next contended cycle goes to the read, and vice versa, so no write waits more than 1 contended cycle.
- `RAM_STREAM_CTRL_RR_ARB_EN` undefined: fixed priority, where the write always wins and reads stall for as long as `wr_req` stays high.

## Test plan
- Preload words 0..7 with 0x100+i via `wr_req`, then `start` with `start_addr`=2, `len`=4 and `ready`=1. Expected: beats 0x102..0x105 on 4 consecutive cycles starting 2 cycles after `start`, `sop` on 0x102, `eop` on 0x105, then `done` one cycle after the 0x105 transfer.
- Burst with `len`=8 while `ready` toggles 1,0,0,1 repeatedly. Expected: all 8 words in order, none lost or duplicated, and output stable on every cycle with `ready`=0.
- `start_addr`=1022, `len`=4. Expected: addresses 1022, 1023, 0, 1 in that order. Burst with `len`=0: no `valid`, and `done` pulses 1 cycle after `start`.
- Hold `wr_req`=1 continuously during a `len`=4 burst:
  - With the macro defined: reads and writes alternate.
  - With the macro undefined: no beats until `wr_req` drops.
  - A write of 0xDEAD to an address not yet read appears as 0xDEAD in the stream.
- Assert `rst`=0 mid-burst after 2 of 6 beats. Expected: all outputs 0 immediately. A new `start` after release yields a clean packet with `sop`.
- `start` pulsed again while `busy`=1. Expected: ignored, and the current packet and `done` are unchanged.

Source files
------------

// File: rtl/ram_stream_ctrl.sv
// Single-port RAM sequencer: arbitrates host word writes against an internal burst
// reader that streams a contiguous range as one Avalon-ST packet. RAM_STREAM_CTRL_RR_ARB_EN selects round-robin arbitration.
module ram_stream_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ack,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WIDTH-1:0]  ram_data,
  output logic              ram_wren,
  input  logic [WIDTH-1:0]  ram_q,
  input  logic              ready,
  output logic [WIDTH-1:0]  data,
  output logic              valid,
  output logic              sop,
  output logic              eop,
  output logic              empty
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sop;
    logic             eop;
  } beat_t;
  typedef struct packed {
    logic sop;
    logic eop;
  } tag_t;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   remain;
  logic              first;
  logic              rd_inflight;
  tag_t              tag_pipe;
  beat_t             fifo [2];
  beat_t             head;
  logic              wp, rp;
  logic [1:0]        cnt;
  logic              pop, push, slot_ok, rd_want, rd_issue, wr_grant, done_nxt;

  assign head    = fifo[rp];
  assign valid   = (cnt != 2'd0);
  assign pop     = valid & ready;
  assign push    = rd_inflight;
  // Occupancy counts data already committed to arrive, so a pop this cycle frees a slot.
  assign slot_ok = (({1'b0, cnt} + 3'(rd_inflight) - 3'(pop)) < 3'd2);
  assign rd_want = (state == STREAM) & slot_ok;

`ifdef RAM_STREAM_CTRL_RR_ARB_EN
  logic rd_turn;
  assign wr_grant = wr_req & rst & ~(rd_want & rd_turn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  rd_turn <= 1'b0;
    else if (wr_req & rd_want) rd_turn <= ~rd_turn;
  end
`else
  assign wr_grant = wr_req & rst;
`endif

  assign rd_issue    = rd_want & ~wr_grant;
  assign wr_ack      = wr_grant;
  assign ram_wren    = wr_grant;
  assign ram_address = wr_grant ? wr_addr : (rd_issue ? rd_ptr : '0);
  assign ram_data    = wr_grant ? wr_data : '0;

  assign data  = valid ? head.data : '0;
  assign sop   = valid & head.sop;
  assign eop   = valid & head.eop;
  assign empty = 1'b0;
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) done_nxt  = 1'b1;
          else           state_nxt = STREAM;
        end
      end
      STREAM: if (rd_issue && remain == LEN_ONE) state_nxt = DRAIN;
      DRAIN: begin
        // eop is the last word issued, so its transfer implies nothing in flight and FIFO empty.
        if (pop && head.eop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      rd_ptr      <= '0;
      remain      <= '0;
      first       <= 1'b0;
      rd_inflight <= 1'b0;
      tag_pipe    <= '0;
    end else begin
      state       <= state_nxt;
      done        <= done_nxt;
      rd_inflight <= rd_issue;
      if (state == IDLE && start) begin
        rd_ptr <= start_addr;
        remain <= len;
        first  <= 1'b1;
      end else if (rd_issue) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        remain   <= remain - LEN_ONE;
        first    <= 1'b0;
        tag_pipe <= '{sop: first, eop: (remain == LEN_ONE)};
      end
    end
  end

  // RAM q arrives one edge after the issue edge, together with its sop/eop tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo[wp] <= '{data: ram_q, sop: tag_pipe.sop, eop: tag_pipe.eop};
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Bench for ram_stream_ctrl: table of bursts, hand sequences for reset and held writes,
// then random bursts checked against a word-array memory model.
module tb_ram_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] len = '0;
  logic        busy, done;
  logic [9:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q = '0;
  logic        ready = 1'b0;
  logic [31:0] data;
  logic        valid, sop, eop, empty;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];

  ram_stream_ctrl #(.WIDTH(32), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .start(start), .start_addr(start_addr), .len(len), .busy(busy),
    .done(done), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .ready(ready), .data(data), .valid(valid), .sop(sop), .eop(eop),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Registered-output single-port RAM
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_sop"}, 32'(sop), 0);
    chk({tag, "_eop"}, 32'(eop), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
    chk({tag, "_ram_wren"}, 32'(ram_wren), 0);
    chk({tag, "_ram_address"}, 32'(ram_address), 0);
    chk({tag, "_ram_data"}, ram_data, 0);
    chk({tag, "_data"}, data, 0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_write(input int a, input logic [31:0] d);
    bit got = 0;
    wr_req = 1'b1; wr_addr = a[9:0]; wr_data = d;
    for (int t = 0; t < 50 && !got; t++) begin
      #1;
      if (wr_ack) got = 1;
      @(negedge clk);
    end
    wr_req = 1'b0;
    if (got) ref_mem[a] = d;
    else chk("write_ack_timeout", 32'(got), 1);
  endtask

  // mode 0: ready=1, 1: ready 1,0,0,1 pattern, 2: random ready.
  // hold>0: wr_req held (addr sa+3, data 0xDEAD) from the start cycle for hold cycles.
  task automatic run_burst(input int sa, input int blen, input int mode, input bit restart,
                           input int hold, output int nb, output logic [31:0] fdata,
                           output logic [31:0] ldata);
    int cyc = 0, first_v = -1, done_c = -1, last_c = -1, budget;
    bit stalled = 0, quiet = 1, extra = 0;
    logic [31:0] pd = '0;
    logic ps = 0, pe = 0;
    bit pat [4] = '{1, 0, 0, 1};
    nb = 0; fdata = '0; ldata = '0;
    budget = 8 * blen + 40 + hold;
    start = 1'b1; start_addr = sa[9:0]; len = blen[10:0];
    if (hold > 0) begin
      wr_req = 1'b1; wr_addr = 10'((sa + 3) % 1024); wr_data = 32'hDEAD;
      ref_mem[(sa + 3) % 1024] = 32'hDEAD;
    end
    @(negedge clk); cyc = 1;
    while (cyc < budget && done_c < 0) begin
      if (hold > 0 && cyc == hold) wr_req = 1'b0;
      if (restart && cyc == 4) begin
        start = 1'b1; start_addr = 10'((sa + 7) % 1024); len = 11'd3;
        chk("busy_at_restart", 32'(busy), 1);
      end else start = 1'b0;
      case (mode)
        0: ready = 1'b1;
        1: ready = pat[cyc % 4];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (hold > 0 && cyc <= hold + 1 && valid) quiet = 0;
      if (done) done_c = cyc;
      if (stalled) begin
        chk("stall_valid", 32'(valid), 1);
        chk("stall_data", data, pd);
        chk("stall_sop", 32'(sop), 32'(ps));
        chk("stall_eop", 32'(eop), 32'(pe));
      end
      if (valid && first_v < 0) first_v = cyc;
      if (valid && ready) begin
        if (nb >= blen) extra = 1;
        else begin
          chk("beat_data", data, ref_mem[(sa + nb) % 1024]);
          chk("beat_sop", 32'(sop), 32'(nb == 0));
          chk("beat_eop", 32'(eop), 32'(nb == blen - 1));
        end
        if (nb == 0) fdata = data;
        ldata = data;
        if (eop) last_c = cyc;
        nb++;
      end
      stalled = valid && !ready; pd = data; ps = sop; pe = eop;
      if (done_c < 0) begin
        @(negedge clk); cyc++;
      end
    end
    start = 1'b0; wr_req = 1'b0;
    chk("done_seen", 32'(done_c >= 0), 1);
    chk("beat_count", 32'(nb), 32'(blen));
    chk("no_extra_beat", 32'(extra), 0);
    chk("busy_low_at_done", 32'(busy), 0);
    if (blen == 0) begin
      chk("len0_done_cycle", 32'(done_c), 1);
      chk("len0_no_valid", 32'(first_v), 32'(-1));
    end else begin
      chk("done_after_eop", 32'(done_c), 32'(last_c + 1));
      if (mode == 0 && hold == 0) begin
        chk("first_valid_cycle", 32'(first_v), 3);
        chk("done_cycle", 32'(done_c), 32'(blen + 3));
      end
    end
`ifndef RAM_STREAM_CTRL_RR_ARB_EN
    if (hold > 0) begin
      chk("held_write_blocks_reads", 32'(quiet), 1);
      chk("first_valid_after_hold", 32'(first_v), 32'(hold + 2));
    end
`endif
    quiet = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (valid || done) quiet = 0;
    end
    chk("quiet_after_done", 32'(quiet), 1);
  endtask

  typedef struct {
    int          sa;
    int          blen;
    int          mode;
    bit          restart;
    int          hold;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int nb, n, t;
    logic [31:0] fd, ld;

    vecs[0] = '{2,    4,    0, 0, 0, 32'h102, 32'h105};
    vecs[1] = '{10,   8,    1, 0, 0, 32'h10A, 32'h111};
    vecs[2] = '{1022, 4,    0, 0, 0, 32'h4FE, 32'h101};
    vecs[3] = '{0,    0,    0, 0, 0, 32'h0,   32'h0};
    vecs[4] = '{300,  6,    0, 1, 0, 32'h22C, 32'h231};
    vecs[5] = '{1023, 1,    1, 0, 0, 32'h4FF, 32'h4FF};
    vecs[6] = '{5,    1024, 2, 0, 0, 32'h105, 32'h104};
    vecs[7] = '{200,  4,    0, 0, 6, 32'h1C8, 32'hDEAD};

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hBAD0_0000 | 32'(i);
      ref_mem[i] = mem[i];
    end

    // Reset state, with wr_req asserted to show wr_ack is held low in reset
    rst = 1'b0; wr_req = 1'b1; wr_addr = 10'd7; wr_data = 32'h1234; ready = 1'b1;
    #3;
    chk_all_zero("reset");
    chk("reset_empty", 32'(empty), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; wr_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 1024; i++) do_write(i, 32'h100 + 32'(i));

    foreach (vecs[i]) begin
      run_burst(vecs[i].sa, vecs[i].blen, vecs[i].mode, vecs[i].restart, vecs[i].hold, nb, fd, ld);
      if (vecs[i].blen > 0) begin
        chk("table_first_word", fd, vecs[i].exp_first);
        chk("table_last_word", ld, vecs[i].exp_last);
      end
    end

    // Reset in the middle of a 6-word burst after 2 beats
    start = 1'b1; start_addr = 10'd100; len = 11'd6; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; t = 0;
    while (n < 2 && t < 30) begin
      if (valid && ready) n++;
      @(negedge clk); t++;
    end
    chk("midburst_two_beats", 32'(n), 2);
    #2;
    rst = 1'b0; wr_req = 1'b1; wr_addr = 10'd50; wr_data = 32'hFFFF_FFFF;
    #1;
    chk_all_zero("midburst_reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    run_burst(50, 3, 0, 0, 0, nb, fd, ld);
    chk("post_reset_first", fd, 32'h132);

    // Random bursts with random preceding writes and random backpressure
    for (int r = 0; r < 25; r++) begin
      int nw, sa, bl;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) do_write($urandom_range(0, 1023), $urandom);
      sa = $urandom_range(0, 1023);
      bl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 40);
      run_burst(sa, bl, 2, 0, 0, nb, fd, ld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
